// File: rtl/gs_pkg.sv
// rtl/gs_pkg.sv - shared types and constants for the Goldschmidt sequencer
//
// Purpose: FSM state type, multiplier operand select encodings, operation
// encoding and the default refinement iteration count.
package gs_pkg;

  localparam int ITERS_DEFAULT = 4;

  localparam logic [1:0] OP_DIV = 2'b00;

  // Multiplier A operand selects
  localparam logic [1:0] SEL_A_N    = 2'b00;
  localparam logic [1:0] SEL_A_D    = 2'b01;
  localparam logic [1:0] SEL_A_INIT = 2'b11;

  // Multiplier B operand selects
  localparam logic [1:0] SEL_B_K    = 2'b00;
  localparam logic [1:0] SEL_B_DK   = 2'b01;
  localparam logic [1:0] SEL_B_ONE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC_K,
    S_MUL_N,
    S_MUL_D,
    S_MUL_D2,
    S_FINAL,
    S_DONE
  } gs_state_t;

endpackage

// File: rtl/gs_iter_counter.sv
// rtl/gs_iter_counter.sv - Goldschmidt refinement iteration counter
//
// Purpose: counts completed refinement iterations.
// Ports:
//   clk, reset (async, active-low)
//   clr  - synchronous clear to 0 (takes priority over inc)
//   inc  - count up by one
//   last - terminal-count flag: the next increment reaches ITERS
module gs_iter_counter #(
  parameter int ITERS = 4,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Flag is raised one increment early so the FSM can pick FINAL on the
  // same edge the count reaches ITERS; the count therefore never passes ITERS.
  assign last = (count == CNT_W'(ITERS - 1));

endmodule

// File: rtl/gs_sequencer.sv
// rtl/gs_sequencer.sv - shared divide/square-root Goldschmidt control FSM
//
// Purpose: sequences the mantissa datapath through load, ITERS refinement
// iterations and final quotient/root capture, for divide or square root.
// Ports:
//   clk, reset (async, active-low)
//   start, op        - request and operation (00 divide, else square root)
//   ready, busy, done - status; done is a one-cycle completion pulse
//   op_q             - operation latched at acceptance, to the datapath
//   sA, sB           - multiplier operand selects
//   enableN, enableD, enableK, enableQD - datapath register load enables
module gs_sequencer
  import gs_pkg::*;
#(
  parameter int ITERS = ITERS_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] op_q,
  output logic [1:0] sA,
  output logic [1:0] sB,
  output logic       enableN,
  output logic       enableD,
  output logic       enableK,
  output logic       enableQD
);

  gs_state_t state;
  gs_state_t next_state;

  logic accept;
  logic iter_end;
  logic last_iter;

  assign accept = (state == S_IDLE) && start;

  // Divide finishes an iteration after MUL_D; square root needs the extra
  // D*K*K step in MUL_D2.
  assign iter_end = ((state == S_MUL_D) && (op_q == OP_DIV)) || (state == S_MUL_D2);

  gs_iter_counter #(
    .ITERS(ITERS),
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .inc  (iter_end),
    .last (last_iter)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q  <= OP_DIV;
    end else begin
      state <= next_state;
      if (accept) begin
        op_q <= op;
      end
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    sA         = SEL_A_N;
    sB         = SEL_B_K;
    enableN    = 1'b0;
    enableD    = 1'b0;
    enableK    = 1'b0;
    enableQD   = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        sA         = SEL_A_INIT;
        sB         = SEL_B_ONE;
        enableN    = 1'b1;
        enableD    = 1'b1;
        next_state = S_CALC_K;
      end
      S_CALC_K: begin
        enableK    = 1'b1;
        next_state = S_MUL_N;
      end
      S_MUL_N: begin
        sA         = SEL_A_N;
        sB         = SEL_B_K;
        enableN    = 1'b1;
        next_state = S_MUL_D;
      end
      S_MUL_D: begin
        sA      = SEL_A_D;
        sB      = SEL_B_K;
        enableD = 1'b1;
        if (op_q != OP_DIV) begin
          next_state = S_MUL_D2;
        end else begin
          next_state = last_iter ? S_FINAL : S_CALC_K;
        end
      end
      S_MUL_D2: begin
        sA         = SEL_A_D;
        sB         = SEL_B_DK;
        enableD    = 1'b1;
        next_state = last_iter ? S_FINAL : S_CALC_K;
      end
      S_FINAL: begin
        enableQD   = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule
